// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the decoder: control-transfer
// encodings, FSM state codes and the default reset/exception vectors.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    CT_SEQ    = 2'd0,
    CT_BRANCH = 2'd1,
    CT_JUMP   = 2'd2,
    CT_JR     = 2'd3
  } ctrl_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00400000;
  localparam logic [31:0] EXC_PC_DEFAULT   = 32'h80000180;

  // Branch displacement: sign-extended 16-bit word offset turned into bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ack/data back.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection from the decoder's control-transfer type.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] inst,
  input  logic [31:0] rs_data,
  input  ctrl_t       control_type,
  output logic [31:0] next_pc
);

  // Pick the target; jr silently drops the two low address bits.
  always_comb begin
    next_pc = pc_plus4;
    unique case (control_type)
      CT_SEQ:    next_pc = pc_plus4;
      CT_BRANCH: next_pc = pc_plus4 + branch_offset(inst[15:0]);
      CT_JUMP:   next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
      CT_JR:     next_pc = {rs_data[31:2], 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-state fetch/execute sequencer: fetches one instruction, holds it for
// the execute stage, then advances the PC (or vectors to the exception PC).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  fetch_unit_if.master       imem,
  output logic [31:0]        inst,
  output logic               inst_valid,
  input  logic               exec_done,
  input  logic [1:0]         control_type,
  input  logic               except,
  input  logic [31:0]        rs_data,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        epc
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] sel_pc;
  // Low until the first edge after reset release, so an ack that coincides
  // with the release cycle is not mistaken for a response to a real request.
  logic        armed_reg;

  assign pc             = pc_reg;
  assign pc_plus4       = pc_reg + 32'd4;
  assign inst           = inst_reg;
  assign epc            = epc_reg;
  assign imem.imem_addr = pc_reg;

  next_pc_sel u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .inst         (inst_reg),
    .rs_data      (rs_data),
    .control_type (ctrl_t'(control_type)),
    .next_pc      (sel_pc)
  );

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_FETCH;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'd0;
      epc_reg   <= 32'd0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      epc_reg   <= epc_next;
      armed_reg <= 1'b1;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_next     = inst_reg;
    epc_next      = epc_reg;
    imem.imem_req = 1'b0;
    inst_valid    = 1'b0;
    unique case (state_reg)
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack && armed_reg) begin
          inst_next  = imem.imem_rdata;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        inst_valid = 1'b1;
        if (exec_done) begin
          state_next = ST_FETCH;
          if (except) begin
            pc_next  = EXC_PC;
            epc_next = pc_reg;
          end else begin
            pc_next = sel_pc;
          end
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h00400000, PC loaded on reset.
REQ-002 SHALL have parameter EXC_PC, 32'h80000180, PC loaded when an exception is taken.
REQ-003 SHALL have port clock  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  out  32  read address, equal to pc.
REQ-007 SHALL have port imem_ack  in  1  read data valid this cycle.
REQ-008 SHALL have port imem_rdata  in  32  instruction word.
REQ-009 SHALL have port inst  out  32  held instruction, sliced by the decoder for opcode/funct.
REQ-010 SHALL have port inst_valid  out  1  inst is valid for decode/execute.
REQ-011 SHALL have port exec_done  in  1  execute stage has consumed inst.
REQ-012 SHALL have port control_type  in  2  from decoder: 0 sequential, 1 branch taken, 2 jump, 3 jump-register.
REQ-013 SHALL have port except  in  1  from decoder, exception on current inst.
REQ-014 SHALL have port rs_data  in  32  register rs value, jr target.
REQ-015 SHALL have ports pc, pc_plus4, epc  out  32 each.

Function
REQ-016 SHALL implement a two-state FSM, FETCH and EXEC.
REQ-017 In FETCH: imem_req=1, inst_valid=0; on an edge with imem_ack=1, inst<=imem_rdata, go to EXEC.
REQ-018 In FETCH with imem_ack=0: hold state, pc, and inst; imem_req stays 1.
REQ-019 In EXEC: imem_req=0, inst_valid=1; imem_ack is ignored.
REQ-020 In EXEC with exec_done=0: hold all state.
REQ-021 In EXEC with exec_done=1: pc<=next_pc, go to FETCH.
REQ-022 pc_plus4 SHALL equal pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-023 next_pc for control_type 0 SHALL be pc_plus4.
REQ-024 next_pc for control_type 1 SHALL be pc_plus4 + (sign-extended inst[15:0] << 2), modulo 2^32.
REQ-025 next_pc for control_type 2 SHALL be {pc_plus4[31:28], inst[25:0], 2'b00}.
REQ-026 next_pc for control_type 3 SHALL be {rs_data[31:2], 2'b00}; the low bits are silently cleared.
REQ-027 except=1 with exec_done=1 SHALL override control_type: pc<=EXC_PC, epc<=pc; epc is otherwise held.
REQ-028 except and control_type SHALL be sampled only in EXEC with exec_done=1.
REQ-029 Minimum latency SHALL be 2 cycles per instruction: ack edge, then exec_done edge.
REQ-030 imem_addr SHALL be driven combinationally from pc and stay stable while imem_req=1.

Reset
REQ-031 Reset low SHALL asynchronously force: state=FETCH, pc=RESET_PC, inst=0, epc=0.
REQ-032 After reset deasserts, imem_req=1 and inst_valid=0 in the first cycle.
REQ-033 Reset asserted mid-fetch or mid-execute SHALL abandon the in-flight operation.
REQ-034 After reset, an imem_ack arriving in the same cycle reset deasserts SHALL be ignored.

Structure
REQ-035 control_type encodings, FSM state codes, and RESET_PC/EXC_PC defaults SHALL live in the shared define/package file used by the decoder.
REQ-036 Next-PC selection SHALL be one combinational sub-module, next_pc_sel, instantiated once.

Verification
REQ-037 Reset pulse, ack 2 cycles later with rdata=0x00000020 -> imem_addr=0x00400000 throughout; inst=0x00000020 and inst_valid=1 after the ack edge.
REQ-038 Branch: pc=0x00400004, inst[15:0]=0xFFFE, control_type=1, exec_done -> pc=0x00400000.
REQ-039 Jump: pc=0x00400010, inst[25:0]=26'h0100003, control_type=2 -> pc=0x0040000C.
REQ-040 Jump-register: rs_data=0x00400023, control_type=3 -> pc=0x00400020.
REQ-041 Exception: except=1, control_type=2 at pc=0x00400008 -> pc=0x80000180, epc=0x00400008.
REQ-042 Reset mid-EXEC with exec_done=0 -> immediate pc=0x00400000, inst_valid=0, imem_req=1 after release.
